// File: rtl/scb_pip1_pkg.sv
// Shared widths, pipe codes and helpers for the pip1 scoreboard controller.
package scb_pip1_pkg;
  localparam int N_CELL  = 8;
  localparam int W_ident = 4;
  localparam int W_pip   = 2;
  localparam int W_PA_rx = 5;
  localparam int W_state = 7;
  localparam int D_RES   = (1 << W_state) + 1;
  localparam int W_WB    = 1 + W_pip + W_PA_rx;
  localparam int W_RIDX  = W_state + 1;

  localparam logic [W_pip-1:0]   V_pip0  = 2'b01;
  localparam logic [W_pip-1:0]   V_pip1  = 2'b10;
  localparam logic [W_ident-1:0] ID_NONE = '1;

  typedef struct packed {
    logic               ready;
    logic [W_pip-1:0]   pip;
    logic [W_PA_rx-1:0] rd;
  } cand_wb_t;

  // Extract one cell's {ready,pip,rd} record from the flattened candidate bus.
  function automatic cand_wb_t cand_wb_slice(input logic [N_CELL*W_WB-1:0] v, input int idx);
    return cand_wb_t'(v[idx*W_WB +: W_WB]);
  endfunction
endpackage

// File: rtl/scb_pip1_prio_sel.sv
// Lowest-index picker: reports whether any request is set and which one wins.
module scb_pip1_prio_sel #(
  parameter int N     = 8,
  parameter int W_IDX = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [W_IDX-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = W_IDX'(i);
      end
    end
  end
endmodule

// File: rtl/scb_ctrl_pip1.sv
// pip1 scoreboard controller: issue acceptance with per-pipe writeback slot
// reservation, free-cell selection, writeback grants and conflict detection.
module scb_ctrl_pip1
  import scb_pip1_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      CFI_PC_clear,
  input  logic                      issue_valid,
  input  logic [W_pip-1:0]          issue_pip,
  input  logic [W_PA_rx-1:0]        issue_rd,
  input  logic [W_state-1:0]        issue_state,
  output logic                      issue_ready,
  output logic [W_ident-1:0]        addr_insert,
  output logic [W_pip-1:0]          o_pip,
  output logic [W_PA_rx-1:0]        o_rd,
  output logic [W_state-1:0]        o_state,
  input  logic [N_CELL*W_WB-1:0]    cell_candit_wb,
  input  logic [N_CELL*W_ident-1:0] cell_candit_insert,
  output logic                      wb0_valid,
  output logic [W_PA_rx-1:0]        wb0_rd,
  output logic [W_ident-1:0]        wb0_cell,
  output logic                      wb1_valid,
  output logic [W_PA_rx-1:0]        wb1_rd,
  output logic [W_ident-1:0]        wb1_cell,
  output logic [W_ident-1:0]        occupancy,
  output logic                      wb_conflict
);
  localparam int W_IDX = $clog2(N_CELL);

  // Handshake: a request transfers in the cycle issue_valid && issue_ready;
  // issue_ready is combinational and the requester holds its fields until then.
  logic [D_RES-1:0]   res0, res1, res_sel, res_set;
  logic               clear_hold;
  logic [W_pip-1:0]   pip_q;
  logic [W_PA_rx-1:0] rd_q;
  logic [W_state-1:0] state_q;

  cand_wb_t           cand [N_CELL];
  logic [N_CELL-1:0]  free_vec, wb0_req, wb1_req;
  logic [W_ident-1:0] busy_cnt;
  logic [W_RIDX-1:0]  slot;
  logic               free_ok, wb0_found, wb1_found, pip_ok, accept;
  logic               multi0, multi1;
  logic [W_IDX-1:0]   free_idx, wb0_idx, wb1_idx;

  always_comb begin
    cand     = '{default: '0};
    free_vec = '0;
    wb0_req  = '0;
    wb1_req  = '0;
    busy_cnt = '0;
    for (int i = 0; i < N_CELL; i++) begin
      cand[i]     = cand_wb_slice(cell_candit_wb, i);
      free_vec[i] = cell_candit_insert[i*W_ident +: W_ident] != ID_NONE;
      // Stale cells are about to be flushed, so their completions are ignored.
      wb0_req[i]  = cand[i].ready && (cand[i].pip == V_pip0) && !CFI_PC_clear;
      wb1_req[i]  = cand[i].ready && (cand[i].pip == V_pip1) && !CFI_PC_clear;
      busy_cnt    = busy_cnt + W_ident'(~free_vec[i]);
    end
  end

  scb_pip1_prio_sel #(.N(N_CELL)) u_free_sel (.req(free_vec), .found(free_ok),   .idx(free_idx));
  scb_pip1_prio_sel #(.N(N_CELL)) u_wb0_sel  (.req(wb0_req),  .found(wb0_found), .idx(wb0_idx));
  scb_pip1_prio_sel #(.N(N_CELL)) u_wb1_sel  (.req(wb1_req),  .found(wb1_found), .idx(wb1_idx));

  // Slot s+1 is checked now; after this edge's shift it sits at bit s, i.e.
  // the cycle in which the loaded cell reports ready.
  always_comb begin
    slot        = W_RIDX'(issue_state) + W_RIDX'(1);
    pip_ok      = (issue_pip == V_pip0) || (issue_pip == V_pip1);
    res_sel     = (issue_pip == V_pip1) ? res1 : res0;
    accept      = issue_valid && free_ok && !clear_hold && !CFI_PC_clear && !rst &&
                  pip_ok && !res_sel[slot];
    issue_ready = accept;
    addr_insert = accept ? cell_candit_insert[free_idx*W_ident +: W_ident] : ID_NONE;
    o_pip       = accept ? issue_pip   : pip_q;
    o_rd        = accept ? issue_rd    : rd_q;
    o_state     = accept ? issue_state : state_q;
    res_set       = '0;
    res_set[slot] = accept;
  end

  always_comb begin
    wb0_valid = wb0_found && !rst;
    wb0_rd    = cand[wb0_idx].rd;
    wb0_cell  = W_ident'(wb0_idx);
    wb1_valid = wb1_found && !rst;
    wb1_rd    = cand[wb1_idx].rd;
    wb1_cell  = W_ident'(wb1_idx);
    multi0    = |(wb0_req & (wb0_req - N_CELL'(1)));
    multi1    = |(wb1_req & (wb1_req - N_CELL'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res0        <= '0;
      res1        <= '0;
      clear_hold  <= 1'b1;
      occupancy   <= '0;
      wb_conflict <= 1'b0;
      pip_q       <= '0;
      rd_q        <= '0;
      state_q     <= '0;
    end else begin
      if (CFI_PC_clear) begin
        res0 <= '0;
        res1 <= '0;
      end else begin
        res0 <= (res0 | ((issue_pip == V_pip0) ? res_set : '0)) >> 1;
        res1 <= (res1 | ((issue_pip == V_pip1) ? res_set : '0)) >> 1;
      end
      clear_hold <= CFI_PC_clear;
      occupancy  <= busy_cnt;
      if (multi0 || multi1) wb_conflict <= 1'b1;
      if (accept) begin
        pip_q   <= issue_pip;
        rd_q    <= issue_rd;
        state_q <= issue_state;
      end
    end
  end
endmodule
